// File: rtl/bus_arbiter_pkg.sv
// Shared definitions for the bus arbiter and its OAM DMA engine:
// default widths, register addresses and the DMA sequencer state encoding.
package bus_arbiter_pkg;

    localparam int          DEF_REG_WIDTH    = 8;
    localparam int          DEF_ADDR_WIDTH   = 16;
    localparam int          DMA_IDX_WIDTH    = 8;
    localparam logic [15:0] DEF_OAM_DMA_REG  = 16'h4014;
    localparam logic [15:0] DEF_OAM_DATA_REG = 16'h2004;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DMA_HALT  = 3'd1,
        ST_DMA_ALIGN = 3'd2,
        ST_DMA_READ  = 3'd3,
        ST_DMA_WRITE = 3'd4
    } dma_state_e;

endpackage

// File: rtl/bus_arbiter_if.sv
// Requester/memory bus bundle: the arbiter takes the slave view, the
// requesters and memory model take the master view.
interface bus_arbiter_if
    import bus_arbiter_pkg::*;
#(
    parameter int REG_WIDTH  = DEF_REG_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH
) ();

    logic                  fetch_req;
    logic [ADDR_WIDTH-1:0] fetch_addr;
    logic                  fetch_gnt;
    logic                  exec_req;
    logic                  exec_we;
    logic [ADDR_WIDTH-1:0] exec_addr;
    logic [REG_WIDTH-1:0]  exec_wdata;
    logic                  exec_gnt;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic                  mem_we;
    logic [REG_WIDTH-1:0]  mem_wdata;
    logic [REG_WIDTH-1:0]  mem_rdata;
    logic                  cpu_stall;
    logic                  dma_active;

    modport slave (
        input  fetch_req, fetch_addr, exec_req, exec_we, exec_addr, exec_wdata, mem_rdata,
        output fetch_gnt, exec_gnt, mem_addr, mem_we, mem_wdata, cpu_stall, dma_active
    );

    modport master (
        output fetch_req, fetch_addr, exec_req, exec_we, exec_addr, exec_wdata, mem_rdata,
        input  fetch_gnt, exec_gnt, mem_addr, mem_we, mem_wdata, cpu_stall, dma_active
    );

endinterface

// File: rtl/bus_arbiter_oam_dma_engine.sv
// OAM DMA sequencer: halt, optional alignment cycle, then 256 read/write
// pairs copying one page into the OAM data register.
module oam_dma_engine
    import bus_arbiter_pkg::*;
#(
    parameter int                    REG_WIDTH    = DEF_REG_WIDTH,
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA_REG = ADDR_WIDTH'(DEF_OAM_DATA_REG)
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  trigger,
    input  logic [REG_WIDTH-1:0]  trigger_page,
    input  logic [REG_WIDTH-1:0]  mem_rdata,
    output logic                  dma_active,
    output logic [ADDR_WIDTH-1:0] dma_addr,
    output logic                  dma_we,
    output logic [REG_WIDTH-1:0]  dma_wdata
);

    dma_state_e                 state_r;
    dma_state_e                 state_nxt_s;
    logic [REG_WIDTH-1:0]       page_r;
    logic [REG_WIDTH-1:0]       buf_r;
    logic [DMA_IDX_WIDTH-1:0]   idx_r;
    logic                       parity_r;

    // Next-state decode and per-state bus drive
    always_comb begin
        state_nxt_s = state_r;
        dma_addr    = {ADDR_WIDTH{1'b0}};
        dma_we      = 1'b0;
        dma_wdata   = {REG_WIDTH{1'b0}};
        case (state_r)
            ST_IDLE: begin
                if (trigger) state_nxt_s = ST_DMA_HALT;
                else         state_nxt_s = ST_IDLE;
            end
            ST_DMA_HALT: begin
                // An odd halt cycle needs one extra cycle to line up reads
                if (parity_r) state_nxt_s = ST_DMA_ALIGN;
                else          state_nxt_s = ST_DMA_READ;
            end
            ST_DMA_ALIGN: begin
                state_nxt_s = ST_DMA_READ;
            end
            ST_DMA_READ: begin
                dma_addr    = ADDR_WIDTH'({page_r, idx_r});
                state_nxt_s = ST_DMA_WRITE;
            end
            ST_DMA_WRITE: begin
                dma_addr  = OAM_DATA_REG;
                dma_we    = 1'b1;
                dma_wdata = buf_r;
                if (idx_r == 8'hFF) state_nxt_s = ST_IDLE;
                else                state_nxt_s = ST_DMA_READ;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, page/index/buffer registers and the free-running parity bit
    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            page_r   <= {REG_WIDTH{1'b0}};
            buf_r    <= {REG_WIDTH{1'b0}};
            idx_r    <= 8'd0;
            parity_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            parity_r <= ~parity_r;
            if (state_r == ST_IDLE && trigger)  page_r <= trigger_page;
            if (state_r == ST_DMA_READ)         buf_r  <= mem_rdata;
            if (state_r == ST_DMA_WRITE)        idx_r  <= idx_r + 8'd1;
        end
    end

    assign dma_active = (state_r != ST_IDLE);

endmodule

// File: rtl/bus_arbiter.sv
// Shared memory bus arbiter: exec beats fetch in the same cycle, and the
// OAM DMA engine takes the whole bus while it runs.
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int                    REG_WIDTH    = DEF_REG_WIDTH,
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] OAM_DMA_REG  = ADDR_WIDTH'(DEF_OAM_DMA_REG),
    parameter logic [ADDR_WIDTH-1:0] OAM_DATA_REG = ADDR_WIDTH'(DEF_OAM_DATA_REG)
) (
    input  logic          phi1,
    input  logic          reset_n,
    bus_arbiter_if.slave  bus
);

    logic                  dma_active_s;
    logic [ADDR_WIDTH-1:0] dma_addr_s;
    logic                  dma_we_s;
    logic [REG_WIDTH-1:0]  dma_wdata_s;
    logic                  trigger_s;
    logic                  fetch_gnt_s;
    logic                  exec_gnt_s;
    logic [ADDR_WIDTH-1:0] mem_addr_s;
    logic                  mem_we_s;
    logic [REG_WIDTH-1:0]  mem_wdata_s;
    logic                  cpu_stall_s;
    logic                  dma_active_out_s;

    // Only a granted exec write to the trigger register starts a DMA
    assign trigger_s = reset_n && !dma_active_s && bus.exec_req && bus.exec_we &&
                       (bus.exec_addr == OAM_DMA_REG);

    oam_dma_engine #(
        .REG_WIDTH    (REG_WIDTH),
        .ADDR_WIDTH   (ADDR_WIDTH),
        .OAM_DATA_REG (OAM_DATA_REG)
    ) u_dma (
        .phi1         (phi1),
        .reset_n      (reset_n),
        .trigger      (trigger_s),
        .trigger_page (bus.exec_wdata),
        .mem_rdata    (bus.mem_rdata),
        .dma_active   (dma_active_s),
        .dma_addr     (dma_addr_s),
        .dma_we       (dma_we_s),
        .dma_wdata    (dma_wdata_s)
    );

    // Bus ownership mux; reset forces every output low whatever is requested
    always_comb begin
        fetch_gnt_s      = 1'b0;
        exec_gnt_s       = 1'b0;
        mem_addr_s       = {ADDR_WIDTH{1'b0}};
        mem_we_s         = 1'b0;
        mem_wdata_s      = {REG_WIDTH{1'b0}};
        cpu_stall_s      = 1'b0;
        dma_active_out_s = 1'b0;
        if (!reset_n) begin
            cpu_stall_s = 1'b0;
        end else if (dma_active_s) begin
            mem_addr_s       = dma_addr_s;
            mem_we_s         = dma_we_s;
            mem_wdata_s      = dma_wdata_s;
            cpu_stall_s      = 1'b1;
            dma_active_out_s = 1'b1;
        end else if (bus.exec_req) begin
            exec_gnt_s  = 1'b1;
            mem_addr_s  = bus.exec_addr;
            mem_we_s    = bus.exec_we;
            mem_wdata_s = bus.exec_wdata;
        end else if (bus.fetch_req) begin
            fetch_gnt_s = 1'b1;
            mem_addr_s  = bus.fetch_addr;
        end else begin
            cpu_stall_s = 1'b0;
        end
    end

    assign bus.fetch_gnt  = fetch_gnt_s;
    assign bus.exec_gnt   = exec_gnt_s;
    assign bus.mem_addr   = mem_addr_s;
    assign bus.mem_we     = mem_we_s;
    assign bus.mem_wdata  = mem_wdata_s;
    assign bus.cpu_stall  = cpu_stall_s;
    assign bus.dma_active = dma_active_out_s;

endmodule

// File: tb/tb_bus_arbiter.sv
// Scoreboard bench for bus_arbiter: a transaction-level model expands each
// DMA into a cycle plan; a monitor compares every cycle's bus against it.
`timescale 1ns/1ps
module tb_bus_arbiter;

    typedef struct packed {
        logic        fg;
        logic        eg;
        logic [15:0] addr;
        logic        we;
        logic [7:0]  wd;
        logic        stall;
        logic        act;
    } exp_t;

    logic phi1 = 1'b0;
    logic reset_n = 1'b0;
    logic [7:0] mem [0:65535];

    bus_arbiter_if #(.REG_WIDTH(8), .ADDR_WIDTH(16)) bus ();

    bus_arbiter dut (
        .phi1    (phi1),
        .reset_n (reset_n),
        .bus     (bus)
    );

    always #5 phi1 = ~phi1;
    assign bus.mem_rdata = mem[bus.mem_addr];

    exp_t sb[$];
    exp_t plan[$];
    logic m_par = 1'b0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   stall_run = 0;
    int   last_run = 0;
    int   writes_seen = 0;
    logic [15:0] last_read = 16'h0000;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    task automatic build_plan(input logic [7:0] page, input logic halt_par);
        exp_t e;
        e = '0;
        e.stall = 1'b1;
        e.act   = 1'b1;
        plan.push_back(e);
        if (halt_par) plan.push_back(e);
        for (int i = 0; i < 256; i++) begin
            e.addr = {page, 8'(i)};
            e.we   = 1'b0;
            e.wd   = 8'h00;
            plan.push_back(e);
            e.addr = 16'h2004;
            e.we   = 1'b1;
            e.wd   = mem[{page, 8'(i)}];
            plan.push_back(e);
        end
    endtask

    // One bus cycle: drive inputs, predict outputs, queue the prediction
    task automatic step(input logic rn, input logic fr, input logic [15:0] fa,
                        input logic er, input logic ew, input logic [15:0] ea,
                        input logic [7:0] wd);
        exp_t e;
        @(posedge phi1);
        #1;
        reset_n        = rn;
        bus.fetch_req  = fr;
        bus.fetch_addr = fa;
        bus.exec_req   = er;
        bus.exec_we    = ew;
        bus.exec_addr  = ea;
        bus.exec_wdata = wd;
        e = '0;
        if (!rn) begin
            plan.delete();
            m_par = 1'b0;
        end else begin
            if (plan.size() > 0) begin
                e = plan.pop_front();
            end else if (er) begin
                e.eg = 1'b1; e.addr = ea; e.we = ew; e.wd = wd;
                if (ew && ea == 16'h4014) build_plan(wd, ~m_par);
            end else if (fr) begin
                e.fg = 1'b1; e.addr = fa;
            end
            m_par = ~m_par;
        end
        sb.push_back(e);
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 8'h00);
    endtask

    // Requests during DMA are random but never a second trigger
    task automatic finish_dma();
        while (plan.size() > 0)
            step(1'b1, 1'($urandom), 16'h8123, 1'($urandom), 1'($urandom), 16'h0300, 8'hA5);
        idle();
        idle();
    endtask

    task automatic trigger_dma(input logic [7:0] page, input logic want_par);
        if (m_par != want_par) idle();
        writes_seen = 0;
        step(1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 16'h4014, page);
    endtask

    // Monitor: compare the bus against the oldest prediction every cycle
    initial begin
        exp_t a, e;
        forever begin
            @(negedge phi1);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                a.fg = bus.fetch_gnt; a.eg = bus.exec_gnt; a.addr = bus.mem_addr;
                a.we = bus.mem_we; a.wd = bus.mem_wdata; a.stall = bus.cpu_stall;
                a.act = bus.dma_active;
                chk("bus_cycle", 64'(a), 64'(e));
                if (a.stall) begin
                    stall_run++;
                    if (a.we && a.addr == 16'h2004) writes_seen++;
                    if (!a.we && a.addr != 16'h0000) last_read = a.addr;
                end else if (stall_run > 0) begin
                    last_run  = stall_run;
                    stall_run = 0;
                end
            end
        end
    end

    initial begin
        #700000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        bus.fetch_req = 1'b0; bus.fetch_addr = 16'h0000; bus.exec_req = 1'b0;
        bus.exec_we = 1'b0; bus.exec_addr = 16'h0000; bus.exec_wdata = 8'h00;

        step(1'b0, 1'b1, 16'h8000, 1'b1, 1'b1, 16'h4014, 8'h02);
        step(1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 16'h0000, 8'h00);
        step(1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, 16'h0000, 8'h00);
        step(1'b1, 1'b1, 16'h8000, 1'b1, 1'b1, 16'h0200, 8'h55);
        idle();
        step(1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h4014, 8'h02);
        idle();
        idle();

        trigger_dma(8'h02, 1'b0);
        finish_dma();
        chk("stall_len_par1", 64'(last_run), 64'd514);
        chk("writes_par1", 64'(writes_seen), 64'd256);
        chk("last_read_p02", 64'(last_read), 64'h02FF);

        trigger_dma(8'h02, 1'b1);
        finish_dma();
        chk("stall_len_par0", 64'(last_run), 64'd513);
        chk("writes_par0", 64'(writes_seen), 64'd256);

        trigger_dma(8'hFF, 1'($urandom));
        finish_dma();
        chk("writes_pageFF", 64'(writes_seen), 64'd256);
        chk("last_read_pageFF", 64'(last_read), 64'hFFFF);

        trigger_dma(8'h03, 1'b1);
        while (!(plan.size() > 0 && plan[0].we && writes_seen == 9)) idle();
        step(1'b0, 1'b1, 16'h8000, 1'b0, 1'b0, 16'h0000, 8'h00);
        step(1'b1, 1'b1, 16'h8000, 1'b0, 1'b0, 16'h0000, 8'h00);
        idle();
        idle();
        chk("writes_before_abort", 64'(writes_seen), 64'd9);

        for (int i = 0; i < 3000; i++)
            step(1'($urandom_range(0, 299) != 0), 1'($urandom), 16'($urandom),
                 1'($urandom_range(0, 2) == 0), 1'($urandom),
                 ($urandom_range(0, 9) == 0) ? 16'h4014 : 16'($urandom), 8'($urandom));
        finish_dma();

        @(negedge phi1);
        #1;
        chk("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
